event_encoder: RTL and testbench

//   Turns N asynchronous request lines into a stream of binary event codes.

---
 rtl/event_encoder.sv | 147 ++++++++++++++
 tb/tb_event_encoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/event_encoder.sv
// event_encoder: collapses N asynchronous request lines into a stream of
// binary event codes. Each rising edge on req[i] queues event i in a pending
// bitmap; pending events drain one at a time over a valid/ready handshake.
// Optional feature macro: ENCODER_RR_EN (round-robin selection instead of
// fixed highest-index priority).
module event_encoder #(
   parameter int N           = 4,
   parameter int W           = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [W-1:0] code,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pend,
   output logic         overflow
);

   typedef enum logic {IDLE, PRESENT} state_t;

   logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
   logic [N-1:0]                  prev_q, prev_d;
   logic [N-1:0]                  pend_q, pend_d;
   logic [W-1:0]                  code_q, code_d;
   logic                          valid_q, valid_d;
   logic                          overflow_q, overflow_d;
   state_t                        state_q, state_d;

   logic [N-1:0] sync_out;
   logic [N-1:0] rise;
   logic [N-1:0] cap;
   logic [N-1:0] acc_mask;
   logic         accept;
   logic [W-1:0] sel;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_q;
   assign cap      = en ? rise : '0;
   assign accept   = valid_q && ready;
   assign acc_mask = accept ? (N'(1) << code_q) : '0;

   // Synchroniser shift chain and edge-history register.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
      prev_d    = sync_out;
   end

   // Pending bitmap: accepted bit clears, captured edges set. An edge on the
   // bit being accepted this cycle re-queues it instead of overflowing.
   always_comb begin
      pend_d     = (pend_q & ~acc_mask) | cap;
      overflow_d = |(cap & pend_q & ~acc_mask);
   end

`ifdef ENCODER_RR_EN
   logic [W-1:0] last_q, last_d;

   // Round-robin pick: first pending bit at or after last_grant+1, wrapping.
   always_comb begin
      int idx;
      idx = 0;
      sel = '0;
      for (int k = N-1; k >= 0; k--) begin
         idx = (int'(last_q) + 1 + k) % N;
         if (pend_q[idx]) sel = W'(idx);
      end
   end

   // Remember the most recently accepted code.
   always_comb begin
      last_d = last_q;
      if (accept) last_d = code_q;
   end

   // last_grant register; reset to N-1 so the first search starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= W'(N-1);
      else        last_q <= last_d;
   end
`else
   // Fixed priority: highest pending index wins (later iterations override).
   always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++) begin
         if (pend_q[i]) sel = W'(i);
      end
   end
`endif

   // Presentation FSM: latch a code from IDLE, hold it stable until accepted.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (pend_q != '0) begin
               code_d  = sel;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset clears everything including queued events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         prev_q     <= '0;
         pend_q     <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         pend_q     <= pend_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
      end
   end

   assign code     = code_q;
   assign valid    = valid_q;
   assign pend     = pend_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: directed vectors for event_encoder (N=4, W=2, 2 sync
// stages). Inputs change and outputs are sampled on the falling clock edge.
module tb_event_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic [1:0] code;
   logic       valid;
   logic       ready;
   logic [3:0] pend;
   logic       overflow;

   int nvec = 0;
   int nerr = 0;

   event_encoder #(.N(4), .W(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .code(code),
      .valid(valid), .ready(ready), .pend(pend), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_valid();
      int t = 0;
      while (valid !== 1'b1 && t < 20) begin
         step();
         t++;
      end
      chk("valid_timeout", {31'd0, valid}, 1);
   endtask

   initial begin
      logic [1:0] exp2 [2];
      logic [1:0] exp6 [4];
      int ovf_cnt;
`ifdef ENCODER_RR_EN
      exp2 = '{2'd1, 2'd3};
      exp6 = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
      exp2 = '{2'd3, 2'd1};
      exp6 = '{2'd3, 2'd2, 2'd1, 2'd0};
`endif
      rst_n = 1'b0; en = 1'b0; req = '0; ready = 1'b0;
      step(); step();
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_code", {30'd0, code}, 0);
      chk("rst_pend", {28'd0, pend}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      rst_n = 1'b1;
      step();

      // 1: single pulse on req[0], exact latency
      en = 1'b1; ready = 1'b1; req = 4'b0001;
      step(); req = '0;
      chk("t1_valid_k1", {31'd0, valid}, 0);
      step();
      chk("t1_pend_k2", {28'd0, pend}, 0);
      step();
      chk("t1_pend_k3", {28'd0, pend}, 4'b0001);
      chk("t1_valid_k3", {31'd0, valid}, 0);
      step();
      chk("t1_valid_k4", {31'd0, valid}, 1);
      chk("t1_code", {30'd0, code}, 0);
      step();
      chk("t1_valid_acc", {31'd0, valid}, 0);
      chk("t1_pend_acc", {28'd0, pend}, 0);

      // 2: two simultaneous edges, held level
      req = 4'b1010;
      step(); step(); step();
      chk("t2_pend", {28'd0, pend}, 4'b1010);
      step();
      chk("t2_valid_a", {31'd0, valid}, 1);
      chk("t2_code_a", {30'd0, code}, {30'd0, exp2[0]});
      step();
      chk("t2_pend_a", {28'd0, pend}, 4'b1010 & ~(4'b0001 << exp2[0]));
      chk("t2_ovf_a", {31'd0, overflow}, 0);
      step();
      chk("t2_code_b", {30'd0, code}, {30'd0, exp2[1]});
      chk("t2_valid_b", {31'd0, valid}, 1);
      step();
      chk("t2_pend_b", {28'd0, pend}, 0);
      chk("t2_ovf_b", {31'd0, overflow}, 0);
      req = '0;
      repeat (4) step();

      // 3: backpressure with re-pulse on pending bit
      ready = 1'b0; req = 4'b0100;
      step(); req = '0;
      step(); step(); step();
      chk("t3_valid", {31'd0, valid}, 1);
      chk("t3_code", {30'd0, code}, 2);
      ovf_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 1) req = 4'b0100;
         if (c == 2) req = '0;
         step();
         chk("t3_code_hold", {30'd0, code}, 2);
         chk("t3_valid_hold", {31'd0, valid}, 1);
         chk("t3_pend_hold", {28'd0, pend}, 4'b0100);
         if (overflow === 1'b1) ovf_cnt++;
      end
      chk("t3_ovf_pulses", ovf_cnt, 1);
      ready = 1'b1;
      step();
      chk("t3_pend_acc", {28'd0, pend}, 0);
      chk("t3_valid_acc", {31'd0, valid}, 0);

      // 4: edge while disabled is discarded, also after enabling
      en = 1'b0; req = 4'b0010;
      repeat (6) step();
      chk("t4_pend_dis", {28'd0, pend}, 0);
      chk("t4_valid_dis", {31'd0, valid}, 0);
      en = 1'b1;
      repeat (6) step();
      chk("t4_pend_en", {28'd0, pend}, 0);
      chk("t4_valid_en", {31'd0, valid}, 0);
      req = '0;
      repeat (4) step();

      // 5: asynchronous reset while presenting
      ready = 1'b0; req = 4'b0110;
      step(); req = '0;
      step(); step(); step();
      chk("t5_valid_pre", {31'd0, valid}, 1);
      chk("t5_pend_pre", {28'd0, pend}, 4'b0110);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_valid_async", {31'd0, valid}, 0);
      chk("t5_code_async", {30'd0, code}, 0);
      chk("t5_pend_async", {28'd0, pend}, 0);
      step();
      rst_n = 1'b1; ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("t5_quiet_valid", {31'd0, valid}, 0);
         chk("t5_quiet_pend", {28'd0, pend}, 0);
      end

      // 6: all four pending at once, drain order depends on selection
      req = 4'b1111;
      step(); req = '0;
      step(); step();
      chk("t6_pend", {28'd0, pend}, 4'b1111);
      for (int e = 0; e < 4; e++) begin
         wait_valid();
         chk("t6_code", {30'd0, code}, {30'd0, exp6[e]});
         step();
      end
      chk("t6_pend_end", {28'd0, pend}, 0);
      chk("t6_valid_end", {31'd0, valid}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
